// File: rtl/arith_pkg.sv
// Shared types and helpers for the ArithmeticOps group.
package arith_pkg;

  // Widest operand the helpers handle; callers extend to this width and truncate back.
  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude of a sign-extended operand when signed_mode is set, otherwise the raw value.
  function automatic word_t abs_val(input word_t x, input logic signed_mode);
    return (signed_mode && x[MAX_W-1]) ? (~x + word_t'(1)) : x;
  endfunction

  // Two's-complement negation when neg is set.
  function automatic word_t cond_neg(input word_t x, input logic neg);
    return neg ? (~x + word_t'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift {rem, quo} left and trial-subtract.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Keep the trial difference when it does not borrow; the extra bit holds the shifted-out MSB.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned divider, one restoring iteration per clock.
module seq_div
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned      CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_n;
  logic             accept_c;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             neg_quo, neg_rem, dbz_q, ovf_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next state; a zero divisor skips the iterations entirely.
  always_comb begin
    state_n  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          accept_c = 1'b1;
          state_n  = (b == '0) ? DONE : CALC;
        end
      end
      CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result finalisation out of DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      busy <= (state_n == CALC);
      done <= (state_q == DONE);
      if (state_q == DONE) begin
        quotient    <= dbz_q ? '1 : WIDTH'(cond_neg(MAX_W'(quo_q), neg_quo));
        remainder   <= dbz_q ? rem_q : WIDTH'(cond_neg(MAX_W'(rem_q), neg_rem));
        div_by_zero <= dbz_q;
        overflow    <= ovf_q;
      end
      if (accept_c) begin
        cnt_q   <= '0;
        // On divide-by-zero rem_q carries the raw dividend straight to the remainder.
        rem_q   <= (b == '0) ? a : '0;
        quo_q   <= WIDTH'(abs_val(MAX_W'($signed(a)), signed_mode));
        div_q   <= WIDTH'(abs_val(MAX_W'($signed(b)), signed_mode));
        neg_quo <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem <= signed_mode & a[WIDTH-1];
        dbz_q   <= (b == '0);
        ovf_q   <= signed_mode && (a == MIN_V) && (b == '1);
      end else if (state_q == CALC) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= (cnt_q == CNT_W'(WIDTH - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div (WIDTH=8): directed scenarios plus random operations.
module tb_seq_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division, with the two exceptional cases spelled out.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic sm, input int acc);
    exp_t e;
    int   sa, sd;
    e.acc = acc;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (ib == 0) begin
      e.q  = 8'hFF;
      e.r  = ia;
      e.dz = 1'b1;
    end else if (sm) begin
      sa = int'($signed(ia));
      sd = int'($signed(ib));
      if (sa == -128 && sd == -1) begin
        e.q  = 8'h80;
        e.r  = 8'h00;
        e.ov = 1'b1;
      end else begin
        e.q = W'(sa / sd);
        e.r = W'(sa % sd);
      end
    end else begin
      e.q = ia / ib;
      e.r = ia % ib;
    end
    return e;
  endfunction

  // Monitor: pops on every done, otherwise checks that results are held.
  logic [W-1:0] last_q = '0, last_r = '0;
  logic         last_dz = 1'b0, last_ov = 1'b0;
  int           busy_cnt = 0;
  exp_t         m;

  always @(negedge clk) begin
    if (rst) begin
      last_q = '0; last_r = '0; last_dz = 1'b0; last_ov = 1'b0;
      busy_cnt = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          m = sb.pop_front();
          chk("quotient", int'(quotient), int'(m.q));
          chk("remainder", int'(remainder), int'(m.r));
          chk("div_by_zero", int'(div_by_zero), int'(m.dz));
          chk("overflow", int'(overflow), int'(m.ov));
          chk("done_latency", cyc - m.acc, m.dz ? 1 : W + 1);
          chk("busy_cycles", busy_cnt, m.dz ? 0 : W);
          last_q = m.q; last_r = m.r; last_dz = m.dz; last_ov = m.ov;
        end
        busy_cnt = 0;
      end else begin
        chk("held_results", int'({quotient, remainder, div_by_zero, overflow}),
            int'({last_q, last_r, last_dz, last_ov}));
      end
      if (busy) busy_cnt++;
    end
  end

  // Wait for an idle slot, then present one start for a single cycle.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic sm, input bit push);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("issue_timeout", 1, 0);
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    if (push) sb.push_back(model(ia, ib, sm, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 1, 0);
  endtask

  logic [W-1:0] ra, rb;
  logic         rs;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_results", int'({quotient, remainder, div_by_zero, overflow}), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Unsigned, divide-by-zero, signed sign cases, overflow and its unsigned twin.
    issue(8'h09, 8'h02, 1'b0, 1'b1);
    issue(8'h09, 8'h00, 1'b0, 1'b1);
    issue(8'hF9, 8'h02, 1'b1, 1'b1);
    issue(8'h07, 8'hFE, 1'b1, 1'b1);
    issue(8'h80, 8'hFF, 1'b1, 1'b1);
    issue(8'h80, 8'hFF, 1'b0, 1'b1);

    // Start during CALC is ignored; start in the done cycle is accepted.
    issue(8'd200, 8'd3, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", int'(busy), 1);
    wait_done();
    a = 8'd50; b = 8'd7; signed_mode = 1'b0; start = 1'b1;
    sb.push_back(model(8'd50, 8'd7, 1'b0, cyc + 1));
    @(negedge clk);
    start = 1'b0;

    // Reset mid-CALC aborts with no done pulse.
    issue(8'd255, 8'd1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    chk("async_reset_results", int'({quotient, remainder, div_by_zero, overflow}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'd100, 8'd10, 1'b0, 1'b1);

    // Random operations with random gaps, biased towards the corner operands.
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 8'h00;
        1: begin ra = 8'h80; rb = 8'hFF; end
        2: rb = 8'h01;
        default: ;
      endcase
      issue(ra, rb, rs, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", int'(sb.size()), 0);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
